// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button input conditioner.
package button_pkg;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 240_000;

    // Counter must hold 0 .. cycles-1 without wrapping.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_input_conditioner_sync_chain.sv
// N-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_input_conditioner.sv
// Synchronizes and debounces one raw button level, producing a clean
// level plus one-cycle press/release/change strobes.
module button_input_conditioner
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic button_sync,
    output logic button_state,
    output logic button_event,
    output logic button_pressed,
    output logic button_released
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          state;
    logic [CW-1:0] cnt;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (in),
        .q  (button_sync)
    );

    // Any sample agreeing with the current level restarts qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= 1'b0;
            cnt             <= '0;
            button_event    <= 1'b0;
            button_pressed  <= 1'b0;
            button_released <= 1'b0;
        end else begin
            button_event    <= 1'b0;
            button_pressed  <= 1'b0;
            button_released <= 1'b0;
            if (button_sync == state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                state           <= button_sync;
                cnt             <= '0;
                button_event    <= 1'b1;
                button_pressed  <= button_sync;
                button_released <= ~button_sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign button_state = state;

endmodule

// File: tb/tb_button_input_conditioner.sv
// Directed bench for button_input_conditioner with 2 sync stages, 8-cycle debounce.
module tb_button_input_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic button_sync;
    logic button_state;
    logic button_event;
    logic button_pressed;
    logic button_released;

    int checks = 0;
    int errors = 0;

    int n_press;
    int n_rel;
    int n_evt;
    int n_both;
    int n_evt_bad;
    int n_alt_bad;
    int n_state_hi;
    int last_kind;

    button_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in             (in),
        .button_sync    (button_sync),
        .button_state   (button_state),
        .button_event   (button_event),
        .button_pressed (button_pressed),
        .button_released(button_released)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        n_press    = 0;
        n_rel      = 0;
        n_evt      = 0;
        n_both     = 0;
        n_evt_bad  = 0;
        n_alt_bad  = 0;
        n_state_hi = 0;
        last_kind  = 0;
    endtask

    // One rising edge, then sample 1 ns later and tally strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (button_pressed) n_press++;
        if (button_released) n_rel++;
        if (button_event) n_evt++;
        if (button_pressed && button_released) n_both++;
        if (button_event !== (button_pressed | button_released)) n_evt_bad++;
        if (button_state) n_state_hi++;
        if (button_pressed) begin
            if (last_kind == 1) n_alt_bad++;
            last_kind = 1;
        end
        if (button_released) begin
            if (last_kind != 1) n_alt_bad++;
            last_kind = 2;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int outs();
        return {27'd0, button_sync, button_state, button_event,
                button_pressed, button_released};
    endfunction

    initial begin
        clear_counts();

        // Reset with in low
        ticks(3);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        ticks(20);
        chk("idle_no_event", n_evt, 0);
        chk("idle_state", int'(button_state), 0);

        // Press: sync after 2 edges, state after 10
        clear_counts();
        in = 1'b1;
        tick();
        chk("press_sync_e1", int'(button_sync), 0);
        tick();
        chk("press_sync_e2", int'(button_sync), 1);
        ticks(7);
        chk("press_state_e9", int'(button_state), 0);
        tick();
        chk("press_state_e10", int'(button_state), 1);
        chk("press_pulse_e10", int'(button_pressed), 1);
        chk("press_event_e10", int'(button_event), 1);
        tick();
        chk("press_pulse_e11", int'(button_pressed), 0);
        ticks(10);
        chk("press_count", n_press, 1);
        chk("press_evt_count", n_evt, 1);
        chk("press_no_release", n_rel, 0);

        // Release
        clear_counts();
        in = 1'b0;
        ticks(9);
        chk("rel_state_e9", int'(button_state), 1);
        tick();
        chk("rel_state_e10", int'(button_state), 0);
        chk("rel_pulse_e10", int'(button_released), 1);
        ticks(10);
        chk("rel_count", n_rel, 1);
        chk("rel_evt_count", n_evt, 1);
        chk("rel_no_press", n_press, 0);

        // Bounce: 5 high, 1 low, 7 high -- longest run 7 < 8
        clear_counts();
        in = 1'b1;
        ticks(5);
        in = 1'b0;
        ticks(1);
        in = 1'b1;
        ticks(7);
        in = 1'b0;
        ticks(15);
        chk("bounce_no_event", n_evt, 0);
        chk("bounce_state_never_hi", n_state_hi, 0);

        // Reset mid-count with in held high
        clear_counts();
        in = 1'b1;
        ticks(5);
        rst = 1'b1;
        #1;
        chk("midrst_cleared", outs(), 0);
        ticks(2);
        chk("midrst_held", outs(), 0);
        rst = 1'b0;
        ticks(9);
        chk("midrst_state_e9", int'(button_state), 0);
        tick();
        chk("midrst_pulse_e10", int'(button_pressed), 1);
        ticks(10);
        chk("midrst_press_count", n_press, 1);

        // Bring back to released before the toggle run
        in = 1'b0;
        ticks(15);
        chk("pre_toggle_state", int'(button_state), 0);

        // Three press/release cycles of 15 cycles per phase
        clear_counts();
        for (int k = 0; k < 3; k++) begin
            in = 1'b1;
            ticks(15);
            in = 1'b0;
            ticks(15);
        end
        chk("toggle_press", n_press, 3);
        chk("toggle_release", n_rel, 3);
        chk("toggle_event", n_evt, 6);
        chk("toggle_alternate", n_alt_bad, 0);
        chk("toggle_no_overlap", n_both, 0);
        chk("toggle_event_or", n_evt_bad, 0);
        chk("toggle_final_state", int'(button_state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_input_conditioner.md
# button_input_conditioner

Conditions one raw, asynchronous, active-high push-button level into clean single-clock-domain signals. A multi-flop synchronizer feeds a counter-based debouncer. The block outputs a debounced level plus one-cycle press, release and change strobes. It sits between a board pin (inverted upstream if the pin is active-low) and control logic such as a metronome speed toggle.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count; legal range ≥2.
- `DEBOUNCE_CYCLES`, default 240_000 (10 ms at 24 MHz): consecutive stable cycles required to accept a new level; legal range ≥1.

Ports (direction, width, meaning):
- `clk` input 1: single system clock.
- `rst` input 1: asynchronous, active-high reset.
- `in` input 1: raw, noisy, asynchronous button level; 1 means pressed.
- `button_sync` output 1: synchronized, undebounced level.
- `button_state` output 1: debounced level.
- `button_event` output 1: one-cycle strobe when `button_state` changes in either direction.
- `button_pressed` output 1: one-cycle strobe on a 0→1 change of `button_state`.
- `button_released` output 1: one-cycle strobe on a 1→0 change of `button_state`.

## Operation
- Synchronizer: shift chain of `SYNC_STAGES` flops clocked by `clk`. `in` enters stage 0; `button_sync` is the last stage.
- Debouncer state:
  - `state` (drives `button_state`).
  - Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, unsigned.
- Every cycle:
  - If `button_sync == state`: `cnt <= 0`, no strobe.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `state <= button_sync`, `cnt <= 0`, and assert `button_event`. Also assert `button_pressed` if `button_sync` is 1, or `button_released` if it is 0.
  - Else: `cnt <= cnt+1`, no strobe.
- Any single sample equal to `state` during counting restarts the count; there is no partial credit.
- Strobes are registered and high for exactly one cycle. `button_pressed` and `button_released` are never high together. `button_event` equals `button_pressed | button_released`.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.

## Timing
- Reset (asynchronous assert; deassert is sampled on `clk`): all synchronizer flops, `state`, `cnt` and all strobes go to 0. After reset the button is considered released.
- Synchronizer latency: `button_sync` reflects `in` `SYNC_STAGES` rising edges after `in` is sampled.
- Debounce latency: `button_state` changes on the `DEBOUNCE_CYCLES`-th consecutive edge at which `button_sync != state`. Total latency from a clean step on `in` to `button_state` is `SYNC_STAGES + DEBOUNCE_CYCLES` cycles.
- Strobes are asserted in the same cycle as the first cycle of the new `button_state` value.
- With `DEBOUNCE_CYCLES=1`, `button_state` follows `button_sync` with one cycle of delay, and a strobe fires on every change.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles, as seen at `button_sync`, produces no change and no strobe.
- Reset asserted mid-count: the count is discarded. If `in` is held high through reset, the press is re-qualified after reset deasserts and produces one `button_pressed`.

## Structure
- Shared package `button_pkg`:
  - `DEFAULT_SYNC_STAGES = 2`.
  - `DEFAULT_DEBOUNCE_CYCLES = 240_000`.
  - Helper function for the counter width.
- One sub-module, `sync_chain`: a parameterized N-flop synchronizer with async reset. The top instantiates it once and implements the debouncer counter and strobe logic inline.
- No FSM beyond the one-bit `state` register.

## Test plan
All scenarios use `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=8`.
- Reset with `in=0` → all outputs 0. Hold 20 cycles → no strobe.
- Step `in` 0→1 and hold → `button_sync` rises 2 cycles later; `button_state` rises 10 cycles after the step; `button_pressed` and `button_event` each high exactly 1 cycle; `button_released` stays 0.
- From a debounced 1, step `in` to 0 → `button_released` and `button_event` pulse once, 10 cycles later; `button_state` becomes 0.
- Bounce `in` high for 5 cycles, low for 1, high for 7, then low → no change in `button_state` and no strobes.
- Hold `in`=1 for 5 cycles, assert `rst` for 2 cycles, keep `in`=1 → outputs clear immediately on `rst` assertion. `button_pressed` fires once, 10 cycles after reset deassert.
- Press and release 3 times, each phase 15 cycles → exactly 3 `button_pressed` and 3 `button_released` pulses, alternating, and `button_event` count = 6.
